sram_buffer: RTL and testbench



---
 rtl/sram_buffer.sv | 130 +++++++++++++
 tb/tb_sram_buffer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/sram_buffer.sv
// sram_buffer: multi-word local storage with one write port, one registered
// read port (1-cycle latency), a one-word-per-cycle clear sweep and a
// one-cycle error pulse whenever a request has to be dropped.
module sram_buffer #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  write_enable,
  input  logic [ADDR_WIDTH-1:0] write_addr,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  read_enable,
  input  logic [ADDR_WIDTH-1:0] read_addr,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic                  read_valid,
  output logic                  busy,
  output logic                  error
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic {
    IDLE,
    CLEARING
  } state_t;

  state_t                state;
  state_t                state_next;
  logic [ADDR_WIDTH-1:0] count;
  logic [ADDR_WIDTH-1:0] count_next;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;

  logic [DATA_WIDTH-1:0] read_data_next;
  logic                  read_valid_next;
  logic                  busy_next;
  logic                  error_next;

  // State, sweep counter and all registered outputs; reset wins over everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      count      <= '0;
      read_data  <= '0;
      read_valid <= 1'b0;
      busy       <= 1'b0;
      error      <= 1'b0;
    end else begin
      state      <= state_next;
      count      <= count_next;
      read_data  <= read_data_next;
      read_valid <= read_valid_next;
      busy       <= busy_next;
      error      <= error_next;
    end
  end

  // Storage array: zeroed on reset, otherwise takes the single write chosen below.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // Next-state logic: user traffic in IDLE, sweep writes and request rejection in CLEARING.
  always_comb begin
    state_next      = state;
    count_next      = count;
    read_data_next  = read_data;
    read_valid_next = 1'b0;
    busy_next       = 1'b0;
    error_next      = 1'b0;
    mem_we          = 1'b0;
    mem_waddr       = write_addr;
    mem_wdata       = write_data;

    unique case (state)
      IDLE: begin
        if (clear) begin
          // Clear takes priority; anything requested alongside it is dropped.
          state_next = CLEARING;
          count_next = '0;
          busy_next  = 1'b1;
          error_next = write_enable | read_enable;
        end else begin
          // Read sees pre-edge contents, so a same-address write is read-before-write.
          if (read_enable) begin
            read_data_next  = mem[read_addr];
            read_valid_next = 1'b1;
          end
          if (write_enable) begin
            mem_we = 1'b1;
          end
        end
      end

      CLEARING: begin
        // One word zeroed per cycle; a repeated clear is simply ignored.
        mem_we     = 1'b1;
        mem_waddr  = count;
        mem_wdata  = '0;
        error_next = write_enable | read_enable;
        if (count == {ADDR_WIDTH{1'b1}}) begin
          state_next = IDLE;
          count_next = '0;
          busy_next  = 1'b0;
        end else begin
          count_next = count + 1'b1;
          busy_next  = 1'b1;
        end
      end

      default: begin
        state_next = IDLE;
        count_next = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_sram_buffer.sv
// tb_sram_buffer: directed sequence against a small behavioural model; read
// results are queued when a read is issued and compared when read_valid rises.
module tb_sram_buffer;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic          clk;
  logic          reset;
  logic          clear;
  logic          write_enable;
  logic [AW-1:0] write_addr;
  logic [DW-1:0] write_data;
  logic          read_enable;
  logic [AW-1:0] read_addr;
  logic [DW-1:0] read_data;
  logic          read_valid;
  logic          busy;
  logic          error;

  int testCount = 0;
  int failCount = 0;

  // Behavioural model state
  logic [DW-1:0] modelMem [DEPTH];
  logic          modelClearing = 1'b0;
  int            modelCount    = 0;
  logic [DW-1:0] lastData      = '0;
  logic [DW-1:0] readQueue [$];

  int busyCycles;

  sram_buffer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk         (clk),
    .reset       (reset),
    .clear       (clear),
    .write_enable(write_enable),
    .write_addr  (write_addr),
    .write_data  (write_data),
    .read_enable (read_enable),
    .read_addr   (read_addr),
    .read_data   (read_data),
    .read_valid  (read_valid),
    .busy        (busy),
    .error       (error)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: counts it and reports any disagreement
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of inputs, advance the model, then check outputs after the edge
  task automatic applyStimulus(input logic rst, input logic clr,
                               input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                               input logic re, input logic [AW-1:0] ra);
    logic expValid;
    logic expBusy;
    logic expError;
    logic [DW-1:0] expData;
    reset        = rst;
    clear        = clr;
    write_enable = we;
    write_addr   = wa;
    write_data   = wd;
    read_enable  = re;
    read_addr    = ra;
    expValid = 1'b0;
    expBusy  = 1'b0;
    expError = 1'b0;
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) modelMem[i] = '0;
      modelClearing = 1'b0;
      modelCount    = 0;
      lastData      = '0;
      readQueue.delete();
    end else if (!modelClearing) begin
      if (clr) begin
        modelClearing = 1'b1;
        modelCount    = 0;
        expBusy       = 1'b1;
        expError      = we | re;
      end else begin
        if (re) begin
          readQueue.push_back(modelMem[ra]);
          expValid = 1'b1;
        end
        if (we) modelMem[wa] = wd;
      end
    end else begin
      modelMem[modelCount] = '0;
      expError = we | re;
      if (modelCount == DEPTH - 1) begin
        modelClearing = 1'b0;
        modelCount    = 0;
      end else begin
        modelCount++;
        expBusy = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    checkOutput("read_valid", {31'b0, read_valid}, {31'b0, expValid});
    checkOutput("busy", {31'b0, busy}, {31'b0, expBusy});
    checkOutput("error", {31'b0, error}, {31'b0, expError});
    if (expValid) begin
      if (readQueue.size() == 0) begin
        checkOutput("scoreboard_empty", 32'd1, 32'd0);
      end else begin
        expData  = readQueue.pop_front();
        lastData = expData;
      end
    end
    checkOutput("read_data", {24'b0, read_data}, {24'b0, lastData});
  endtask

  // Convenience wrappers
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0);
  endtask

  task automatic writeWord(input logic [AW-1:0] a, input logic [DW-1:0] d);
    applyStimulus(1'b0, 1'b0, 1'b1, a, d, 1'b0, '0);
  endtask

  task automatic readWord(input logic [AW-1:0] a);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, a);
  endtask

  // Directed sequence
  initial begin
    reset = 1'b1; clear = 1'b0; write_enable = 1'b0; write_addr = '0;
    write_data = '0; read_enable = 1'b0; read_addr = '0;

    // Reset state
    applyStimulus(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, '0);
    applyStimulus(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, '0);
    checkOutput("reset_read_data", {24'b0, read_data}, 32'h0);

    // Basic write then read with 1-cycle latency
    writeWord(4'd3, 8'hA5);
    writeWord(4'd15, 8'h3C);
    readWord(4'd3);
    checkOutput("read_3", {24'b0, read_data}, 32'hA5);
    readWord(4'd15);
    checkOutput("read_15", {24'b0, read_data}, 32'h3C);
    idle(1);
    checkOutput("valid_drop", {31'b0, read_valid}, 32'd0);

    // Same-address collision is read-before-write
    writeWord(4'd7, 8'h11);
    applyStimulus(1'b0, 1'b0, 1'b1, 4'd7, 8'h22, 1'b1, 4'd7);
    checkOutput("collision_old", {24'b0, read_data}, 32'h11);
    readWord(4'd7);
    checkOutput("collision_new", {24'b0, read_data}, 32'h22);

    // Fill, clear, measure busy length, verify all zero
    for (int a = 0; a < DEPTH; a++) writeWord(AW'(a), DW'(a + 8'h80));
    applyStimulus(1'b0, 1'b1, 1'b0, '0, '0, 1'b0, '0);
    busyCycles = int'(busy);
    for (int i = 0; i < 20; i++) begin
      idle(1);
      busyCycles += int'(busy);
    end
    checkOutput("busy_len_fill", busyCycles, 32'd16);
    for (int a = 0; a < DEPTH; a++) readWord(AW'(a));
    idle(1);

    // Requests during the sweep are rejected
    writeWord(4'd2, 8'h44);
    applyStimulus(1'b0, 1'b1, 1'b0, '0, '0, 1'b0, '0);
    idle(2);
    applyStimulus(1'b0, 1'b0, 1'b1, 4'd2, 8'hFF, 1'b0, '0);
    checkOutput("err_write_sweep", {31'b0, error}, 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 4'd2);
    checkOutput("err_read_sweep", {31'b0, error}, 32'd1);
    idle(1);
    checkOutput("err_not_sticky", {31'b0, error}, 32'd0);
    idle(14);
    readWord(4'd2);
    checkOutput("read_2_cleared", {24'b0, read_data}, 32'h0);

    // Clear with simultaneous write, then re-clear mid-sweep
    writeWord(4'd9, 8'h66);
    applyStimulus(1'b0, 1'b1, 1'b1, 4'd9, 8'h55, 1'b0, '0);
    checkOutput("err_clear_write", {31'b0, error}, 32'd1);
    busyCycles = int'(busy);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b0, (i == 5), 1'b0, '0, '0, 1'b0, '0);
      busyCycles += int'(busy);
    end
    checkOutput("busy_len_reclear", busyCycles, 32'd16);
    readWord(4'd9);
    checkOutput("read_9_cleared", {24'b0, read_data}, 32'h0);

    // Reset in the middle of a sweep
    for (int a = 10; a < DEPTH; a++) writeWord(AW'(a), 8'h77);
    readWord(4'd12);
    applyStimulus(1'b0, 1'b1, 1'b0, '0, '0, 1'b0, '0);
    idle(4);
    applyStimulus(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, '0);
    checkOutput("rst_busy", {31'b0, busy}, 32'd0);
    checkOutput("rst_data", {24'b0, read_data}, 32'h0);
    for (int a = 10; a < DEPTH; a++) readWord(AW'(a));
    idle(1);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
